// File: rtl/ps2_pkg.sv
// Shared constants and frame FSM state type for the PS/2 key receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_NONE  = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronizers, clock fall detect, frame FSM and timeout.
// Odd parity is enforced only when PS2_PARITY_CHECK_EN is defined.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       rx_good,
    output logic       rx_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] dat_sync_reg;
    logic                   clk_prev_reg;
    logic                   fall_reg;
    logic                   dat_reg;

    ps2_state_t state_reg, state_next;
    logic [7:0]       shift_reg, shift_next;
    logic [2:0]       bit_cnt_reg, bit_cnt_next;
    logic             par_ok_reg, par_ok_next;
    logic [TMO_W-1:0] tmo_reg, tmo_next;
    logic             good_reg, good_next;
    logic             err_reg, err_next;

    // Idle PS/2 lines float high, so the chains reset to 1 to avoid a false fall.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clock) begin
                if (reset) begin
                    clk_sync_reg[gi] <= 1'b1;
                    dat_sync_reg[gi] <= 1'b1;
                end else if (gi == 0) begin
                    clk_sync_reg[gi] <= ps2_clk;
                    dat_sync_reg[gi] <= ps2_dat;
                end else begin
                    clk_sync_reg[gi] <= clk_sync_reg[gi-1];
                    dat_sync_reg[gi] <= dat_sync_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_prev_reg <= 1'b1;
            fall_reg     <= 1'b0;
            dat_reg      <= 1'b1;
            state_reg    <= IDLE;
            shift_reg    <= 8'h00;
            bit_cnt_reg  <= 3'd0;
            par_ok_reg   <= 1'b0;
            tmo_reg      <= '0;
            good_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            clk_prev_reg <= clk_sync_reg[SYNC_STAGES-1];
            fall_reg     <= clk_prev_reg & ~clk_sync_reg[SYNC_STAGES-1];
            dat_reg      <= dat_sync_reg[SYNC_STAGES-1];
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            par_ok_reg   <= par_ok_next;
            tmo_reg      <= tmo_next;
            good_reg     <= good_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        par_ok_next  = par_ok_reg;
        tmo_next     = tmo_reg;
        good_next    = 1'b0;
        err_next     = 1'b0;

        // Timeout only runs mid-frame; a fall always restarts it.
        if (state_reg != IDLE) begin
            if (fall_reg) begin
                tmo_next = '0;
            end else if (tmo_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                tmo_next   = '0;
                state_next = IDLE;
                err_next   = 1'b1;
            end else begin
                tmo_next = tmo_reg + 1'b1;
            end
        end

        if (fall_reg) begin
            case (state_reg)
                IDLE: begin
                    if (!dat_reg) begin
                        state_next   = DATA;
                        bit_cnt_next = 3'd0;
                        tmo_next     = '0;
                    end
                end
                DATA: begin
                    shift_next   = {dat_reg, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_ok_next = ^{shift_reg, dat_reg};
`else
                    par_ok_next = 1'b1;
`endif
                    state_next = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    if (dat_reg && par_ok_reg) begin
                        good_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign rx_byte = shift_reg;
    assign rx_good = good_reg;
    assign rx_err  = err_reg;

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver top: frame receiver plus break/extended prefix decoder
// holding the current make code. Optional odd-parity check: PS2_PARITY_CHECK_EN.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] keyboard_data,
    output logic       data_valid,
    output logic       frame_error
);

    logic [7:0] rx_byte;
    logic       rx_good;
    logic       rx_err;

    logic [7:0] key_reg;
    logic       valid_reg;
    logic       err_reg;
    logic       ext_flag_reg;
    logic       brk_flag_reg;

    ps2_frame_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame (
        .clock   (clock),
        .reset   (reset),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .rx_byte (rx_byte),
        .rx_good (rx_good),
        .rx_err  (rx_err)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            key_reg      <= PS2_NONE;
            valid_reg    <= 1'b0;
            err_reg      <= 1'b0;
            ext_flag_reg <= 1'b0;
            brk_flag_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            err_reg   <= rx_err;
            if (rx_good) begin
                if (rx_byte == PS2_EXT) begin
                    ext_flag_reg <= 1'b1;
                end else if (rx_byte == PS2_BREAK) begin
                    brk_flag_reg <= 1'b1;
                end else begin
                    // Releasing a key other than the held one leaves the held code alone.
                    if (!brk_flag_reg) begin
                        key_reg <= rx_byte;
                    end else if (rx_byte == key_reg) begin
                        key_reg <= PS2_NONE;
                    end
                    valid_reg    <= 1'b1;
                    ext_flag_reg <= 1'b0;
                    brk_flag_reg <= 1'b0;
                end
            end
        end
    end

    assign keyboard_data = key_reg;
    assign data_valid    = valid_reg;
    assign frame_error   = err_reg;

endmodule
